// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback wrapper around an external combinational ALU, with an 8 x W register file and a carry flag.
// Latency: 2 cycles from accept to commit. E and W forwarding sustains 1 instruction/cycle with no dependency stalls.
// Backpressure: hold freezes E and W, suppresses commit and err, and drops in_ready.
`ifndef WIDTH_WORD
`define WIDTH_WORD 16
`endif

module alu_issue #(
  parameter int W = `WIDTH_WORD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs,
  input  logic [2:0]   in_rt,
  input  logic         in_imm_sel,
  input  logic [W-1:0] in_imm,
  input  logic         hold,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic         alu_carry,
  output logic         wb_valid,
  output logic [2:0]   wb_rd,
  output logic [W-1:0] wb_data,
  output logic         err,
  output logic         flag_c,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MVC = 3'd5;

  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [W-1:0] rf [8];

  logic         e_valid;
  logic [2:0]   e_op;
  logic [2:0]   e_rd;
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;

  logic         w_valid;
  logic [2:0]   w_op;
  logic [2:0]   w_rd;
  logic [W-1:0] w_data;
  logic         w_c;

  logic         accept;
  logic         commit;
  logic         e_legal;
  logic         w_legal;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;

  assign accept   = in_valid & ~hold;
  assign commit   = w_valid & ~hold;
  assign e_legal  = (e_op <= OP_MVC);
  assign w_legal  = (w_op <= OP_MVC);

  assign in_ready = ~hold;
  assign alu_op   = e_op;
  assign alu_a    = e_a;
  assign alu_b    = e_b;
  assign wb_valid = commit;
  assign wb_rd    = w_rd;
  assign wb_data  = w_data;
  assign err      = commit & ~w_legal;
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

  // Operand a: the youngest legal in-flight producer wins, and r0 is always zero.
  always_comb begin
    src_a = rf[in_rs];
    if (in_rs == 3'd0)
      src_a = '0;
    else if (e_valid && e_legal && (e_rd == in_rs))
      src_a = alu_y;
    else if (w_valid && w_legal && (w_rd == in_rs))
      src_a = w_data;
  end

  // Operand b from rt, using the same priority. The immediate mux is applied at load.
  always_comb begin
    src_b = rf[in_rt];
    if (in_rt == 3'd0)
      src_b = '0;
    else if (e_valid && e_legal && (e_rd == in_rt))
      src_b = alu_y;
    else if (w_valid && w_legal && (w_rd == in_rt))
      src_b = w_data;
  end

  // E stage: load on accept. A bubble clears only the valid bit, so the ALU inputs keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_op    <= '0;
      e_rd    <= '0;
      e_a     <= '0;
      e_b     <= '0;
    end else if (!hold) begin
      e_valid <= in_valid;
      if (accept) begin
        e_op <= in_op;
        e_rd <= in_rd;
        e_a  <= src_a;
        e_b  <= in_imm_sel ? in_imm : src_b;
      end
    end
  end

  // W stage: capture the ALU result for the instruction in E on every non-held cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_op    <= '0;
      w_rd    <= '0;
      w_data  <= '0;
      w_c     <= 1'b0;
    end else if (!hold) begin
      w_valid <= e_valid;
      w_op    <= e_op;
      w_rd    <= e_rd;
      w_data  <= alu_y;
      w_c     <= alu_carry;
    end
  end

  // Commit: legal ops write rd (r0 discarded); only ADD/SUB update the carry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      flag_c <= 1'b0;
    end else if (commit && w_legal) begin
      if (w_rd != 3'd0) rf[w_rd] <= w_data;
      if ((w_op == OP_ADD) || (w_op == OP_SUB)) flag_c <= w_c;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against an in-order architectural model.
// The model executes each instruction at accept, in program order. The pipeline's commits must match it.
// Outputs are sampled on the falling edge. Inputs are driven 1 time unit after the rising edge.
module tb_alu_issue;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op, in_rd, in_rs, in_rt;
  logic         in_imm_sel;
  logic [W-1:0] in_imm;
  logic         hold;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_carry;
  logic         wb_valid;
  logic [2:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         err;
  logic         flag_c;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_stray = 0;

  typedef struct {
    logic [2:0]   rd;
    logic [W-1:0] data;
    logic         err;
    int           cyc;
  } commit_t;

  commit_t      exp_q[$];
  commit_t      obs_q[$];
  logic [W-1:0] mreg [8];
  logic         mflag;

  always #5 clk = ~clk;

  alu_issue #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm), .hold(hold),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err), .flag_c(flag_c), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Combinational ALU seen by the wrapper. Illegal ops produce a marker value that must never be forwarded.
  always_comb begin
    alu_y     = '0;
    alu_carry = 1'b0;
    case (alu_op)
      3'd0:    begin alu_y = alu_a + alu_b; alu_carry = (int'(alu_a) + int'(alu_b)) >= (1 << W); end
      3'd1:    begin alu_y = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'd2:    alu_y = alu_a & alu_b;
      3'd3:    alu_y = alu_a | alu_b;
      3'd4:    alu_y = ~alu_a;
      3'd5:    alu_y = alu_b;
      default: alu_y = 16'hDEAD;
    endcase
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mflag = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Architectural execution of one accepted instruction, in program order.
  task automatic model_issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] rt, input logic isel, input logic [W-1:0] imm);
    logic [W-1:0] a, b, y;
    logic         c;
    logic         legal;
    a = mreg[rs];
    b = isel ? imm : mreg[rt];
    c = mflag;
    y = '0;
    legal = (op < 3'd6);
    case (op)
      3'd0:    begin y = a + b; c = (int'(a) + int'(b)) > 65535; end
      3'd1:    begin y = a - b; c = (int'(a) < int'(b)); end
      3'd2:    y = a & b;
      3'd3:    y = a | b;
      3'd4:    y = ~a;
      3'd5:    y = b;
      default: y = '0;
    endcase
    exp_q.push_back('{rd: rd, data: y, err: !legal, cyc: 0});
    if (legal && rd != 3'd0) mreg[rd] = y;
    if (op == 3'd0 || op == 3'd1) mflag = c;
  endtask

  // One clock: capture the falling-edge outputs, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (rst_n && wb_valid) obs_q.push_back('{rd: wb_rd, data: wb_data, err: err, cyc: cyc});
    if (rst_n && err) err_seen++;
    if (rst_n && err && !wb_valid) err_stray++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic isel, input logic [W-1:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm_sel = isel; in_imm = imm;
    if (!hold) model_issue(op, rd, rs, rt, isel, imm);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic peek(input logic [2:0] addr, output logic [W-1:0] val);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; in_op = '0; in_rd = '0; in_rs = '0;
    in_rt = '0; in_imm_sel = 1'b0; in_imm = '0; dbg_addr = 3'd1;
    model_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (wb_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_wb got wb_valid=%b err=%b want 0 0", wb_valid, err); end
    checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", flag_c); end
    checks++; if (alu_op !== 3'd0 || alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_alu got op=%0d a=%h b=%h want 0", alu_op, alu_a, alu_b); end
    checks++; if (wb_rd !== 3'd0 || wb_data !== '0 || dbg_data !== '0) begin errors++; $display("FAIL reset_wbdata got rd=%0d data=%h dbg=%h want 0", wb_rd, wb_data, dbg_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] v;
    issue(3'd5, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    issue(3'd0, 3'd2, 3'd2, 3'd0, 1'b1, 16'h0001);
    issue(3'd5, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234);
    idle(1);
    checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL midop_flag_pre got %b want 1", flag_c); end
    rst_n = 1'b0;
    #2;
    checks++; if (flag_c !== 1'b0 || wb_valid !== 1'b0 || alu_b !== '0) begin errors++; $display("FAIL midop_async got flag=%b wb=%b alu_b=%h want 0", flag_c, wb_valid, alu_b); end
    @(negedge clk); rst_n = 1'b1; model_reset();
    @(posedge clk); #1;
    peek(3'd1, v);
    checks++; if (v !== '0) begin errors++; $display("FAIL midop_r1 got %h want 0000", v); end
    issue(3'd5, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0077);
    idle(3);
    peek(3'd5, v);
    checks++; if (v !== 16'h0077) begin errors++; $display("FAIL midop_next got %h want 0077", v); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midop_commits got %0d want 1", obs_q.size()); end
  endtask

  task automatic test_w_forward();
    logic [W-1:0] v;
    issue(3'd5, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0005);
    issue(3'd2, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000);
    issue(3'd1, 3'd5, 3'd3, 3'd0, 1'b1, 16'h0007);
    checks++; if (alu_op !== 3'd1 || alu_a !== 16'h0005) begin errors++; $display("FAIL wfwd_alu_a got op=%0d a=%h want 1 0005", alu_op, alu_a); end
    idle(3);
    peek(3'd5, v);
    checks++; if (v !== 16'hFFFE) begin errors++; $display("FAIL wfwd_r5 got %h want fffe", v); end
    checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL wfwd_borrow got %b want 1", flag_c); end
    issue(3'd2, 3'd6, 3'd5, 3'd5, 1'b0, 16'h0000);
    idle(3);
    checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL wfwd_and_flag got %b want 1", flag_c); end
  endtask

  task automatic test_e_forward();
    logic [W-1:0] v;
    issue(3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0000);
    idle(3);
    checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL efwd_flag_clear got %b want 0", flag_c); end
    issue(3'd5, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    issue(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001);
    checks++; if (alu_a !== 16'hFFFF) begin errors++; $display("FAIL efwd_alu_a got %h want ffff", alu_a); end
    idle(3);
    peek(3'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL efwd_r2 got %h want 0000", v); end
    checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL efwd_carry got %b want 1", flag_c); end
  endtask

  task automatic test_r0_illegal();
    logic [W-1:0] v;
    int e0;
    issue(3'd5, 3'd0, 3'd0, 3'd0, 1'b1, 16'hAAAA);
    issue(3'd3, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0000);
    idle(3);
    peek(3'd6, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL r0_or got %h want 0000", v); end
    peek(3'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL r0_read got %h want 0000", v); end
    issue(3'd5, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0042);
    idle(3);
    e0 = err_seen;
    issue(3'd6, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0055);
    issue(3'd3, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0000);
    idle(3);
    checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL illegal_err_pulse got %0d cycles want 1", err_seen - e0); end
    peek(3'd1, v);
    checks++; if (v !== 16'h0042) begin errors++; $display("FAIL illegal_r1 got %h want 0042", v); end
    peek(3'd2, v);
    checks++; if (v !== 16'h0042) begin errors++; $display("FAIL illegal_nofwd got %h want 0042", v); end
    checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", flag_c); end
  endtask

  task automatic test_hold();
    int n0;
    logic [W-1:0] v;
    issue(3'd5, 3'd3, 3'd0, 3'd0, 1'b1, 16'h1111);
    issue(3'd0, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0002);
    n0 = obs_q.size();
    hold = 1'b1; in_valid = 1'b1; in_op = 3'd5; in_rd = 3'd7; in_imm_sel = 1'b1; in_imm = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b want 0", in_ready); end
      checks++; if (alu_op !== 3'd0 || alu_a !== 16'h1111 || alu_b !== 16'h0002) begin errors++; $display("FAIL hold_alu got op=%0d a=%h b=%h want 0 1111 0002", alu_op, alu_a, alu_b); end
      cycle();
    end
    checks++; if (obs_q.size() != n0) begin errors++; $display("FAIL hold_commits got %0d want 0", obs_q.size() - n0); end
    hold = 1'b0;
    idle(4);
    checks++;
    if (obs_q.size() < n0 + 2) begin
      errors++; $display("FAIL hold_release got %0d commits want 2", obs_q.size() - n0);
    end else if (obs_q[n0].rd !== 3'd3 || obs_q[n0].data !== 16'h1111 || obs_q[n0+1].rd !== 3'd4 ||
                 obs_q[n0+1].data !== 16'h1113 || obs_q[n0+1].cyc != obs_q[n0].cyc + 1) begin
      errors++; $display("FAIL hold_release got r%0d=%h r%0d=%h gap %0d want r3=1111 r4=1113 gap 1",
        obs_q[n0].rd, obs_q[n0].data, obs_q[n0+1].rd, obs_q[n0+1].data, obs_q[n0+1].cyc - obs_q[n0].cyc);
    end
    peek(3'd7, v);
    checks++; if (v !== mreg[7]) begin errors++; $display("FAIL hold_no_accept got r7=%h want %h", v, mreg[7]); end
  endtask

  task automatic test_streaming();
    int n0;
    logic [W-1:0] v;
    issue(3'd5, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0000);
    idle(3);
    n0 = obs_q.size();
    repeat (8) issue(3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001);
    idle(3);
    peek(3'd1, v);
    checks++; if (v !== 16'h0008) begin errors++; $display("FAIL stream_r1 got %h want 0008", v); end
    checks++;
    if (obs_q.size() != n0 + 8) begin
      errors++; $display("FAIL stream_count got %0d want 8", obs_q.size() - n0);
    end else if (obs_q[n0+7].cyc - obs_q[n0].cyc != 7) begin
      errors++; $display("FAIL stream_span got %0d cycles want 7", obs_q[n0+7].cyc - obs_q[n0].cyc);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int n;
    for (int k = 0; k < 400; k++) begin
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) != 0)
        issue(($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
              3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 16'($urandom));
      else
        idle(1);
    end
    hold = 1'b0;
    idle(4);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].rd !== exp_q[i].rd || obs_q[i].err !== exp_q[i].err ||
          (!exp_q[i].err && obs_q[i].data !== exp_q[i].data)) begin
        errors++; $display("FAIL rand_commit[%0d] got rd=%0d data=%h err=%b want rd=%0d data=%h err=%b",
          i, obs_q[i].rd, obs_q[i].data, obs_q[i].err, exp_q[i].rd, exp_q[i].data, exp_q[i].err);
      end
    end
    for (int r = 0; r < 8; r++) begin
      peek(3'(r), v);
      checks++; if (v !== mreg[r]) begin errors++; $display("FAIL rand_reg r%0d got %h want %h", r, v, mreg[r]); end
    end
    checks++; if (flag_c !== mflag) begin errors++; $display("FAIL rand_flag got %b want %b", flag_c, mflag); end
    checks++; if (err_stray != 0) begin errors++; $display("FAIL err_without_wb got %0d want 0", err_stray); end
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_w_forward();
    test_e_forward();
    test_r0_illegal();
    test_hold();
    test_streaming();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/writeback wrapper around the combinational `alu`. It accepts one instruction per cycle and reads operands from an 8-entry register file. It drives `op`/`a`/`b` to the ALU and captures the ALU's `y`/`carry`. It then commits the result to the register file and a carry flag, forwarding results so that back-to-back dependent instructions need no stall.

## Interface
- `W`, default `` `WIDTH_WORD ``: datapath width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `in_valid` input 1: instruction present.
- `in_ready` output 1: instruction accepted when `in_valid & in_ready`; equals `~hold`.
- `in_op` input 3: ALU opcode.
  - ADD=000, SUB=001, AND=010, OR=011, NOT=100, MVC=101.
  - 110 and 111 are illegal.
- `in_rd`, `in_rs`, `in_rt` input 3 each: destination and source registers.
- `in_imm_sel` input 1: 1 selects `in_imm` as operand b instead of `rt`.
- `in_imm` input W: immediate.
- `hold` input 1: freezes the pipeline.
- `alu_op` output 3, `alu_a` output W, `alu_b` output W: to ALU, driven from E-stage registers.
- `alu_y` input W, `alu_carry` input 1: from ALU, combinational.
- `wb_valid` output 1: commit occurs this cycle.
- `wb_rd` output 3, `wb_data` output W: commit destination and data.
- `err` output 1: one-cycle pulse when an illegal op commits.
- `flag_c` output 1: carry flag.
- `dbg_addr` input 3, `dbg_data` output W: combinational register-file read; r0 reads 0.

## Operation
- **Register file:** r0..r7, each W bits.
  - r0 always reads 0; writes to r0 are discarded.
- **Stage E registers:** `e_valid`, op, rd, a, b.
  - Loaded on accept.
  - `a` = value of `rs`; `b` = `in_imm_sel ? in_imm : value of rt`.
- **Operand source priority, per operand, at accept:**
  - E result (`alu_y`) if `e_valid`, E.rd == src, E.op legal, and src != 0.
  - Otherwise W data if `w_valid`, W.rd == src, W.op legal, and src != 0.
  - Otherwise the register file.
- **Stage W registers:** `w_valid`, op, rd, data = `alu_y`, c = `alu_carry`.
  - Loaded from E each non-held cycle.
  - If no instruction is accepted, `e_valid` becomes 0; likewise `w_valid` follows `e_valid`.
- **Commit:** when `w_valid & ~hold`, `wb_valid` = 1.
  - Legal op: write `rd` ← data at the clock edge.
  - ADD/SUB: `flag_c` ← W.c. ADD gives carry-out; SUB gives borrow, which is 1 when a < b unsigned.
  - AND/OR/NOT/MVC: `flag_c` unchanged.
- **Illegal op:**
  - No register write; flag unchanged.
  - `err` = 1 during the commit cycle.
  - The instruction is never a forwarding source.
- **Hold = 1:**
  - E and W registers freeze.
  - No commit; `wb_valid` = 0, `err` = 0.
  - `in_ready` = 0.
  - `alu_*` outputs stay stable.
- **Reset (async, `rst_n` = 0):** clears everything to 0, including mid-operation; in-flight instructions are dropped.
  - `e_valid`, `w_valid`, `flag_c`, `err`, `wb_valid`, `wb_rd`, `wb_data` = 0.
  - All E and W fields = 0, so `alu_op`/`alu_a`/`alu_b` = 0.
  - All registers = 0.
- **Arithmetic:** all operands and results are W bits, modulo 2^W.

## Timing
- **Instruction accepted at the edge ending cycle N:**
  - It occupies E during N+1; ALU inputs are valid in N+1.
  - It occupies W during N+2; `wb_valid` = 1 in N+2 absent hold.
  - The register file and flag update at the edge ending N+2.
- **Latency:** accept to commit is 2 cycles.
- **Throughput:** 1 instruction per cycle with no dependency stalls.
- **Dependencies:**
  - Dependent instruction accepted in N+1 gets E forwarding.
  - Accepted in N+2, it gets W forwarding.
  - Accepted in N+3 or later, it reads the register file.
- **Hold:** a hold asserted in cycle K blocks the edge ending K. A pending commit occurs in the first cycle with `hold` = 0.
- **Simultaneous commit and dbg read of the same register:** `dbg_data` shows the old value until the edge.

## Test plan
All values assume W = 16.
- **Reset mid-operation:** MVC r1,#0x1234; drop `rst_n` while it sits in W → after release r1 = 0, `flag_c` = 0, no `wb_valid`; the next instruction runs normally.
- **E forwarding:** MVC r1,#0xFFFF, then ADD r2,r1,#1 on the next cycle → `alu_a` = 0xFFFF in the ADD's E cycle; r2 = 0x0000; `flag_c` = 1.
- **W forwarding and borrow:** MVC r3,#5; AND r4,r0,r0; SUB r5,r3,#7 → SUB sees `alu_a` = 5; r5 = 0xFFFE; `flag_c` = 1. A later AND leaves `flag_c` = 1.
- **r0 and illegal op:**
  - MVC r0,#0xAAAA, then OR r6,r0,#0 → r6 = 0.
  - Op 110 to r1 (holding 0x0042) → `err` pulses for 1 cycle; r1 = 0x0042; flag unchanged.
- **Hold:** hold = 1 for 3 cycles with instructions in E and W → `in_ready` = 0, `alu_*` stable, no commits. After release, both commit in order on consecutive cycles with correct data.
- **Streaming:** 8 back-to-back ADD r1,r1,#1 from r1 = 0 → r1 = 8; `wb_valid` high for 8 consecutive cycles.
